gray_bin_conv_stream: RTL and testbench



---
 rtl/gray_bin_pkg.sv | 6 +
 rtl/gray_bin_conv_stream_gray2bin.sv | 13 +
 rtl/gray_bin_conv_stream.sv | 77 +++++++
 tb/tb_gray_bin_conv_stream.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/gray_bin_pkg.sv
// gray_bin_pkg: shared mode encodings and FIFO depth for gray_bin_conv_stream
package gray_bin_pkg;
  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/gray_bin_conv_stream_gray2bin.sv
// gray2bin_comb: pure combinational Gray->binary conversion
// ports: gray (WIDTH) in, bin (WIDTH) out
module gray2bin_comb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  // each binary bit is the xor of all Gray bits at or above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_bin_conv_stream.sv
// gray_bin_conv_stream: streaming Gray<->binary converter with 2-entry output FIFO
// ports: clk_in, rst_in (sync, active-high); in_valid_in/in_ready_out/in_data_in/in_mode_in
// input stream; out_valid_out/out_ready_in/out_data_out/out_mode_out/out_step_err_out output
// stream. Define GRAY_STEP_CHECK_EN to flag mode-0 beats that are not a single Gray step.
module gray_bin_conv_stream
  import gray_bin_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] in_data_in,
  input  logic             in_mode_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] out_data_out,
  output logic             out_mode_out,
  output logic             out_step_err_out
);
  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic             mem_mode [FIFO_DEPTH];
  logic             mem_err  [FIFO_DEPTH];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_nxt;
  logic [WIDTH-1:0] g2b;
  logic             push, pop, step_err;
  gray2bin_comb #(.WIDTH(WIDTH)) u_g2b (.gray(in_data_in), .bin(g2b));
  assign push      = in_valid_in && in_ready_out;
  assign pop       = out_valid_out && out_ready_in;
  assign count_nxt = count + 2'(push) - 2'(pop);
  assign out_valid_out    = count != 2'd0;
  assign out_data_out     = mem_data[rd_ptr];
  assign out_mode_out     = mem_mode[rd_ptr];
  assign out_step_err_out = mem_err[rd_ptr];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count        <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      in_ready_out <= 1'b1;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_data[k] <= '0;
        mem_mode[k] <= 1'b0;
        mem_err[k]  <= 1'b0;
      end
    end else begin
      count        <= count_nxt;
      in_ready_out <= count_nxt != 2'd2;
      if (push) begin
        mem_data[wr_ptr] <= in_mode_in == MODE_B2G ? in_data_in ^ (in_data_in >> 1) : g2b;
        mem_mode[wr_ptr] <= in_mode_in;
        mem_err[wr_ptr]  <= step_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             has_prev;
  // only Gray-input beats are step-checked; a repeat (distance 0) counts as an error
  assign step_err = in_mode_in == MODE_G2B && has_prev && $countones(in_data_in ^ prev_gray) != 1;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_gray <= '0;
      has_prev  <= 1'b0;
    end else if (push && in_mode_in == MODE_G2B) begin
      prev_gray <= in_data_in;
      has_prev  <= 1'b1;
    end
  end
`else
  assign step_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_bin_conv_stream.sv
// tb_gray_bin_conv_stream: randomized + directed self-checking bench against a queue model
module tb_gray_bin_conv_stream;
  localparam int W = 4;
  logic         clk_in = 1'b0;
  logic         rst_in, in_valid_in, in_mode_in, out_ready_in;
  logic [W-1:0] in_data_in;
  logic         in_ready_out, out_valid_out, out_mode_out, out_step_err_out;
  logic [W-1:0] out_data_out;
  typedef struct {
    logic [W-1:0] d;
    logic         m;
    logic         e;
  } beat_t;
  beat_t        q[$];
  logic [W-1:0] prev;
  logic         has_prev;
  int           tests = 0;
  int           fails = 0;
  gray_bin_conv_stream #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .in_data_in(in_data_in), .in_mode_in(in_mode_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .out_data_out(out_data_out), .out_mode_out(out_mode_out),
    .out_step_err_out(out_step_err_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b ^= g >> k;
    return b;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic check_out();
    chk("out_valid", W'(out_valid_out), W'(q.size() != 0));
    chk("in_ready", W'(in_ready_out), W'(q.size() < 2));
    if (q.size() != 0) begin
      chk("out_data", out_data_out, q[0].d);
      chk("out_mode", W'(out_mode_out), W'(q[0].m));
      chk("out_err", W'(out_step_err_out), W'(q[0].e));
    end
  endtask
  task automatic cycle(input logic v, input logic m, input logic [W-1:0] d, input logic ordy);
    logic  in_fire, out_fire;
    beat_t b;
    in_valid_in  = v;
    in_mode_in   = m;
    in_data_in   = d;
    out_ready_in = ordy;
    in_fire  = v && q.size() < 2;
    out_fire = ordy && q.size() != 0;
    @(posedge clk_in);
    #1;
    if (out_fire) void'(q.pop_front());
    if (in_fire) begin
      b.m = m;
      b.d = m ? d ^ (d >> 1) : to_bin(d);
`ifdef GRAY_STEP_CHECK_EN
      b.e = !m && has_prev && $countones(d ^ prev) != 1;
      if (!m) begin
        prev     = d;
        has_prev = 1'b1;
      end
`else
      b.e = 1'b0;
`endif
      q.push_back(b);
    end
    @(negedge clk_in);
    check_out();
  endtask
  task automatic do_reset();
    rst_in      = 1'b1;
    in_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in   = 1'b0;
    q.delete();
    prev     = '0;
    has_prev = 1'b0;
    @(negedge clk_in);
    check_out();
    chk("rst_data", out_data_out, '0);
    chk("rst_mode", W'(out_mode_out), '0);
    chk("rst_err", W'(out_step_err_out), '0);
  endtask
  initial begin
    logic [W-1:0] seq [5];
    logic         exp_err [5];
    in_valid_in  = 1'b0;
    in_mode_in   = 1'b0;
    in_data_in   = '0;
    out_ready_in = 1'b1;
    do_reset();
    cycle(1'b1, 1'b0, 4'b0110, 1'b1);
    chk("ex_g2b", out_data_out, 4'b0100);
    cycle(1'b1, 1'b1, 4'b0101, 1'b1);
    chk("ex_b2g", out_data_out, 4'b0111);
    chk("ex_b2g_mode", W'(out_mode_out), W'(1));
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, W'(i ^ (i >> 1)), 1'b1);
      chk("thru_data", out_data_out, W'(i));
      chk("thru_ready", W'(in_ready_out), W'(1));
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 4'b0001, 1'b0);
    cycle(1'b1, 1'b0, 4'b0011, 1'b0);
    chk("bp_ready", W'(in_ready_out), '0);
    chk("bp_hold", out_data_out, 4'b0001);
    cycle(1'b1, 1'b0, 4'b1111, 1'b0);
    chk("bp_hold2", out_data_out, 4'b0001);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("bp_second", out_data_out, 4'b0010);
    chk("bp_ready_back", W'(in_ready_out), W'(1));
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("bp_drained", W'(out_valid_out), '0);
    cycle(1'b1, 1'b0, 4'b0100, 1'b0);
    cycle(1'b1, 1'b1, 4'b0100, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 4'b0010, 1'b1);
    chk("post_rst_lat", out_data_out, 4'b0011);
    do_reset();
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000};
`ifdef GRAY_STEP_CHECK_EN
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, seq[i], 1'b1);
      chk("step_err", W'(out_step_err_out), W'(exp_err[i]));
      chk("step_data", out_data_out, to_bin(seq[i]));
    end
    cycle(1'b1, 1'b1, 4'b1010, 1'b1);
    chk("step_m1", W'(out_step_err_out), '0);
    cycle(1'b1, 1'b0, 4'b1000, 1'b1);
`ifdef GRAY_STEP_CHECK_EN
    chk("step_wrap", W'(out_step_err_out), '0);
`else
    chk("step_wrap", W'(out_step_err_out), '0);
`endif
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom), 1'($urandom_range(0, 2) != 0));
      if (i == 200) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
